axis_rr_arbiter: RTL and testbench

// - Shares one AXI-Stream master link (toward axis_slave / IO serdes) among N_SRC stream sources.
// - Packet-granular round-robin: a grant is held from the first beat until the tlast handshake.
// - Sits between user-project stream sources and the single FSIC axis link; adds per-source enable and beat status.

---
 rtl/axis_arb_pkg.sv | 19 +
 rtl/axis_rr_pick.sv | 30 +++
 rtl/axis_rr_arbiter.sv | 117 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and the reference round-robin selection rule for the AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK} arb_state_e;

  localparam int unsigned MaxSrc = 8;

  // First requester strictly after ptr, wrapping at n_src; -1 when nobody requests.
  function automatic int rr_next(input logic [MaxSrc-1:0] req, input int unsigned ptr,
                                 input int unsigned n_src);
    int idx;
    rr_next = -1;
    for (int k = int'(n_src); k >= 1; k--) begin
      idx = int'((ptr + k) % n_src);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: lowest requester at or after ptr+1, wrapping.
module axis_rr_pick #(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic             gnt_valid,
  output logic [IdxW-1:0]  gnt_idx
);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  int unsigned        start_idx;
  int unsigned        hit_idx;

  // Rotating the doubled vector puts ptr+1 at bit 0, so a plain priority encode finds the winner.
  always_comb begin
    start_idx = (32'(ptr) + 32'd1) % N_SRC;
    dbl       = {req, req} >> start_idx;
    rot       = dbl[N_SRC-1:0];
    hit_idx   = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) hit_idx = k;
    end
    gnt_valid = |req;
    gnt_idx   = IdxW'((start_idx + hit_idx) % N_SRC);
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master among N_SRC sources.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned UW    = 2,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned SW   = DW / 8,
  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic [N_SRC-1:0]      src_en,
  input  logic [N_SRC-1:0]      s_tvalid,
  input  logic [N_SRC*DW-1:0]   s_tdata,
  input  logic [N_SRC*SW-1:0]   s_tstrb,
  input  logic [N_SRC*SW-1:0]   s_tkeep,
  input  logic [N_SRC-1:0]      s_tlast,
  input  logic [N_SRC*UW-1:0]   s_tuser,
  output logic [N_SRC-1:0]      s_tready,
  output logic                  m_tvalid,
  output logic [DW-1:0]         m_tdata,
  output logic [SW-1:0]         m_tstrb,
  output logic [SW-1:0]         m_tkeep,
  output logic                  m_tlast,
  output logic [UW-1:0]         m_tuser,
  input  logic                  m_tready,
  output logic [IdxW-1:0]       grant_id,
  output logic                  busy,
  output logic [CNTW-1:0]       beat_cnt
);

  arb_state_e      state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] ptr_q;
  logic            busy_q;
  logic [CNTW-1:0] cnt_q;

  logic [N_SRC-1:0] req;
  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;
  logic             hs;
  int unsigned      g;

  assign req = s_tvalid & src_en;

  axis_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Data path is a pure mux while locked so the link adds no latency.
  always_comb begin
    g        = 32'(grant_q);
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    s_tready = '0;
    if (state_q == ARB_LOCK) begin
      m_tvalid    = s_tvalid[g];
      m_tdata     = s_tdata[g*DW +: DW];
      m_tstrb     = s_tstrb[g*SW +: SW];
      m_tkeep     = s_tkeep[g*SW +: SW];
      m_tlast     = s_tlast[g];
      m_tuser     = s_tuser[g*UW +: UW];
      s_tready[g] = m_tready;
    end
  end

  assign hs = m_tvalid & m_tready;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= IdxW'(N_SRC - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (hs) begin
            if (cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
            // The pointer only moves on packet completion, so idle cycles never disturb fairness.
            if (m_tlast) begin
              ptr_q   <= grant_q;
              busy_q  <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench: packet-level source drivers plus a round-robin reference model.
module tb_axis_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_en;
  logic [3:0]   s_tvalid;
  logic [127:0] s_tdata;
  logic [15:0]  s_tstrb;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tlast;
  logic [7:0]   s_tuser;
  logic [3:0]   s_tready;
  logic         m_tvalid;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic [3:0]   m_tkeep;
  logic         m_tlast;
  logic [1:0]   m_tuser;
  logic         m_tready;
  logic [1:0]   grant_id;
  logic         busy;
  logic [3:0]   beat_cnt;

  axis_rr_arbiter #(
    .N_SRC (4),
    .DW    (32),
    .UW    (2),
    .CNTW  (4)
  ) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .src_en    (src_en),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tstrb   (s_tstrb),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tstrb   (m_tstrb),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .m_tready  (m_tready),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Source driver state
  int          pkts_left[4];
  int          beat_idx[4];
  int          len[4];
  int          fixed_len[4];
  logic [31:0] base[4];
  int          stall_cnt[4];
  int          stall_pct;
  int          rdy_mode;

  // Reference model state and logs
  bit exp_lock;
  int exp_grant, exp_ptr, exp_cnt;
  int gl_src[$];
  int gl_cyc[$];
  int delivered[4];
  int dut_hold;

  function automatic logic [31:0] beat_word(int i);
    return base[i] + 32'(beat_idx[i]);
  endfunction

  function automatic int model_pick(logic [3:0] req, int ptr);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic new_packet(int i);
    base[i]     = $urandom;
    len[i]      = (fixed_len[i] > 0) ? fixed_len[i] : int'($urandom_range(1, 5));
    beat_idx[i] = 0;
  endtask

  task automatic load(int i, int npk, int flen);
    pkts_left[i] = npk;
    fixed_len[i] = flen;
    if (npk > 0) new_packet(i);
  endtask

  task automatic drive();
    logic [31:0] w;
    bit st;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 2 == 0);
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < 4; i++) begin
      st = 0;
      if (stall_cnt[i] > 0) begin
        st = 1;
        stall_cnt[i]--;
      end else if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
        st = 1;
      end
      w                   = (pkts_left[i] > 0) ? beat_word(i) : 32'h0;
      s_tvalid[i]         = (pkts_left[i] > 0) && !st;
      s_tdata[i*32 +: 32] = w;
      s_tkeep[i*4 +: 4]   = w[3:0];
      s_tstrb[i*4 +: 4]   = w[7:4];
      s_tuser[i*2 +: 2]   = w[9:8];
      s_tlast[i]          = (pkts_left[i] > 0) && (beat_idx[i] == len[i] - 1);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then drive the next inputs.
  task automatic step_cycle();
    int g, p;
    logic [31:0] ew;
    logic [3:0]  er;
    logic ev, el;
    bit hs, last;
    @(negedge clk);
    g  = exp_grant;
    ev = exp_lock ? s_tvalid[g] : 1'b0;
    ew = (exp_lock && pkts_left[g] > 0) ? beat_word(g) : 32'h0;
    el = exp_lock && pkts_left[g] > 0 && beat_idx[g] == len[g] - 1;
    er = exp_lock ? (4'(m_tready) << g) : 4'h0;
    checks += 7;
    if (m_tvalid !== ev) begin
      errors++; $display("FAIL m_tvalid cyc %0d: got %b want %b", cyc, m_tvalid, ev);
    end
    if (m_tdata !== ew) begin
      errors++; $display("FAIL m_tdata cyc %0d: got %h want %h", cyc, m_tdata, ew);
    end
    if ({m_tstrb, m_tkeep, m_tuser, m_tlast} !== {ew[7:4], ew[3:0], ew[9:8], el}) begin
      errors++; $display("FAIL sideband cyc %0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                         m_tstrb, m_tkeep, m_tuser, m_tlast, ew[7:4], ew[3:0], ew[9:8], el);
    end
    if (s_tready !== er) begin
      errors++; $display("FAIL s_tready cyc %0d: got %b want %b", cyc, s_tready, er);
    end
    if (grant_id !== 2'(exp_grant)) begin
      errors++; $display("FAIL grant_id cyc %0d: got %0d want %0d", cyc, grant_id, exp_grant);
    end
    if (busy !== exp_lock) begin
      errors++; $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, exp_lock);
    end
    if (beat_cnt !== 4'(exp_cnt)) begin
      errors++; $display("FAIL beat_cnt cyc %0d: got %0d want %0d", cyc, beat_cnt, exp_cnt);
    end
    if (busy === 1'b1 && grant_id === 2'd1 && m_tvalid === 1'b0) dut_hold++;
    hs = exp_lock && s_tvalid[g] && m_tready;
    if (!exp_lock) begin
      p = model_pick(s_tvalid & src_en, exp_ptr);
      if (p >= 0) begin
        exp_lock  = 1;
        exp_grant = p;
        exp_cnt   = 0;
        gl_src.push_back(p);
        gl_cyc.push_back(cyc + 1);
      end
    end else if (hs) begin
      last = beat_idx[g] == len[g] - 1;
      delivered[g]++;
      if (exp_cnt < 15) exp_cnt++;
      if (last) begin
        exp_lock = 0;
        exp_ptr  = g;
        pkts_left[g]--;
        if (pkts_left[g] > 0) new_packet(g);
      end else begin
        beat_idx[g]++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while ((pkts_left[0] + pkts_left[1] + pkts_left[2] + pkts_left[3] > 0 || exp_lock)
           && n < budget) begin
      step_cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL drain timeout: got %0d cycles, required fewer", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pkts_left[i] = 0; beat_idx[i] = 0; len[i] = 1; fixed_len[i] = 0; stall_cnt[i] = 0;
      delivered[i] = 0;
    end
    stall_pct = 0;
    rdy_mode  = 0;
    src_en    = 4'hf;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_lock  = 0;
    exp_grant = 0;
    exp_ptr   = 3;
    exp_cnt   = 0;
    dut_hold  = 0;
    gl_src.delete();
    gl_cyc.delete();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    src_en   = 4'hf;
    s_tvalid = 4'hf;
    s_tdata  = '1;
    s_tlast  = '0;
    s_tstrb  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if ({m_tvalid, s_tready, m_tdata} !== '0) begin
      errors++; $display("FAIL reset_datapath: got %b/%b/%h want all zero", m_tvalid, s_tready,
                         m_tdata);
    end
    if ({busy, grant_id} !== 3'b0) begin
      errors++; $display("FAIL reset_state: got busy %b grant %0d want 0/0", busy, grant_id);
    end
    if (beat_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", beat_cnt);
    end
    do_reset();
    repeat (3) step_cycle();
  endtask

  task automatic test_single_src();
    int start;
    do_reset();
    load(0, 1, 3);
    drive();
    start = cyc;
    run_idle(40);
    checks += 5;
    if (gl_src.size() != 1 || gl_src[0] != 0) begin
      errors++; $display("FAIL single_grant: got %0d grants want 1 to src0", gl_src.size());
    end else if (gl_cyc[0] - start != 1) begin
      errors++; $display("FAIL single_latency: got %0d want 1", gl_cyc[0] - start);
    end
    if (delivered[0] != 3) begin
      errors++; $display("FAIL single_beats: got %0d want 3", delivered[0]);
    end
    if (beat_cnt !== 4'd3) begin
      errors++; $display("FAIL single_beat_cnt: got %0d want 3", beat_cnt);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_all_rr();
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 2, 1);
    drive();
    run_idle(60);
    checks++;
    if (gl_src.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d want 8", gl_src.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (gl_src[k] != k % 4) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gl_src[k], k % 4);
        end
        if (k > 0) begin
          checks++;
          if (gl_cyc[k] - gl_cyc[k-1] != 2) begin
            errors++; $display("FAIL rr_gap[%0d]: got %0d want 2", k, gl_cyc[k] - gl_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rdy_mode = 1;
    load(2, 1, 4);
    drive();
    run_idle(40);
    checks += 2;
    if (delivered[2] != 4) begin
      errors++; $display("FAIL bp_beats: got %0d want 4", delivered[2]);
    end
    if (gl_src.size() != 1 || gl_src[0] != 2) begin
      errors++; $display("FAIL bp_grant: got %0d grants want 1 to src2", gl_src.size());
    end
  endtask

  task automatic test_src_en();
    bit cleared = 0;
    int tgt = -1;
    int clr_cyc = 0;
    int hits1 = 0;
    int late2 = 0;
    do_reset();
    src_en = 4'b1101;
    for (int i = 0; i < 4; i++) load(i, 50, 0);
    fixed_len[2] = 4;
    new_packet(2);
    drive();
    for (int n = 0; n < 120; n++) begin
      step_cycle();
      if (!cleared && exp_lock && exp_grant == 2) begin
        cleared   = 1;
        src_en[2] = 1'b0;
        tgt       = pkts_left[2] - 1;
        clr_cyc   = cyc;
      end
    end
    foreach (gl_src[k]) begin
      if (gl_src[k] == 1) hits1++;
      if (gl_src[k] == 2 && gl_cyc[k] > clr_cyc) late2++;
    end
    checks += 3;
    if (hits1 != 0) begin
      errors++; $display("FAIL en_src1_granted: got %0d grants want 0", hits1);
    end
    if (!cleared || pkts_left[2] != tgt) begin
      errors++; $display("FAIL en_src2_complete: got %0d left want %0d", pkts_left[2], tgt);
    end
    if (late2 != 0) begin
      errors++; $display("FAIL en_src2_regrant: got %0d want 0", late2);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    do_reset();
    load(3, 1, 5);
    drive();
    while (!(exp_lock && exp_grant == 3 && beat_idx[3] == 2) && n < 30) begin
      step_cycle();
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++; $display("FAIL rst_mid_setup: got %0d cycles, required fewer", n);
    end
    rst = 1'b1;
    #1;
    checks += 3;
    if ({m_tvalid, s_tready, m_tdata, m_tlast} !== '0) begin
      errors++; $display("FAIL rst_mid_datapath: got %b/%b/%h want all zero", m_tvalid, s_tready,
                         m_tdata);
    end
    if ({busy, grant_id} !== 3'b0) begin
      errors++; $display("FAIL rst_mid_state: got busy %b grant %0d want 0/0", busy, grant_id);
    end
    if (beat_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d want 0", beat_cnt);
    end
    exp_lock = 0; exp_grant = 0; exp_ptr = 3; exp_cnt = 0;
    gl_src.delete();
    gl_cyc.delete();
    load(3, 0, 0);
    load(0, 1, 2);
    load(3, 1, 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    run_idle(40);
    checks++;
    if (gl_src.size() != 2 || gl_src[0] != 0 || gl_src[1] != 3) begin
      errors++; $display("FAIL rst_mid_priority: got %0d grants first %0d want 0 then 3",
                         gl_src.size(), (gl_src.size() > 0) ? gl_src[0] : -1);
    end
  endtask

  task automatic test_valid_drop();
    int n = 0;
    do_reset();
    load(1, 1, 4);
    drive();
    while (!(exp_lock && exp_grant == 1 && beat_idx[1] == 1) && n < 20) begin
      step_cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL drop_setup: got %0d cycles, required fewer", n);
    end
    load(0, 1, 2);
    stall_cnt[1] = 3;
    drive();
    run_idle(40);
    checks += 2;
    if (dut_hold != 3) begin
      errors++; $display("FAIL drop_hold_cycles: got %0d want 3", dut_hold);
    end
    if (gl_src.size() != 2 || gl_src[0] != 1 || gl_src[1] != 0) begin
      errors++; $display("FAIL drop_order: got %0d grants want src1 then src0", gl_src.size());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    load(1, 1, 20);
    drive();
    run_idle(60);
    checks += 2;
    if (beat_cnt !== 4'hf) begin
      errors++; $display("FAIL sat_cnt: got %0d want 15", beat_cnt);
    end
    if (delivered[1] != 20) begin
      errors++; $display("FAIL sat_beats: got %0d want 20", delivered[1]);
    end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    rdy_mode  = 2;
    stall_pct = 25;
    for (int i = 0; i < 4; i++) load(i, 8, 0);
    drive();
    for (int n = 0; n < 300; n++) begin
      if (n % 20 == 0) src_en = 4'($urandom);
      step_cycle();
    end
    src_en = 4'hf;
    run_idle(600);
    total = gl_src.size();
    checks++;
    if (total != 32) begin
      errors++; $display("FAIL random_packets: got %0d grants want 32", total);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_src();
    test_all_rr();
    test_back_pressure();
    test_src_en();
    test_reset_mid_packet();
    test_valid_drop();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
